fetch_stage: RTL and testbench
==============================

# fetch_stage

Instruction-fetch stage of the 3-stage RISC-V core, directly upstream of the control decoder. Owns the PC, drives the synchronous instruction memory (1-cycle read latency), and presents one instruction per cycle to decode, with its opcode/funct3/bit30 fields split out for the control path. Handles decode-side stalls by buffering the returned instruction, and redirects from execute (taken branch, JAL, JALR) by killing the wrong-path instruction. Also counts instructions handed to decode.

## Interface
- `RESET_PC`, 32'h4000_0000: first fetch address after reset.
- `NOP_INST`, 32'h0000_0013: bubble instruction (`addi x0,x0,0`).

- `clk`  input  1  core clock; all state updates on the rising edge.
- `rst`  input  1  synchronous, active-low reset.
- `stall`  input  1  decode cannot accept; the current `inst`/`inst_pc` must be presented again next cycle.
- `redirect`  input  1  execute requests a control-flow change.
- `redirect_pc`  input  32  target address; bits [1:0] are ignored (forced to 00).
- `imem_addr`  output  32  byte address to instruction memory (combinational).
- `imem_en`  output  1  read enable; data returns on `imem_dout` one cycle later.
- `imem_dout`  input  32  instruction memory read data.
- `inst`  output  32  instruction to decode.
- `inst_pc`  output  32  PC of `inst`.
- `inst_valid`  output  1  `inst` is a real, live instruction.
- `opcode`  output  7  `inst[6:0]`.
- `funct3`  output  3  `inst[14:12]`.
- `inst_bit30`  output  1  `inst[30]`.
- `fetch_cnt`  output  32  count of instructions accepted by decode.

## Operation
- Registers:
  - `state` ∈ {BOOT, RUN, HOLD}.
  - `req_pc`: address whose data is on `imem_dout`, or is held.
  - `req_vld`.
  - `hold_inst`.
  - `fetch_cnt`.
- Reset (`rst`=0 at an edge): `state`=BOOT, `req_pc`=RESET_PC, `req_vld`=0, `hold_inst`=NOP_INST, `fetch_cnt`=0. Reset has priority over `redirect` and `stall`.
- BOOT:
  - Outputs: `imem_addr`=RESET_PC, `imem_en`=1, `inst`=NOP_INST, `inst_valid`=0, `inst_pc`=RESET_PC.
  - Next edge: RUN, `req_vld`=1.
- RUN:
  - Outputs: `inst` = `req_vld` ? `imem_dout` : NOP_INST; `inst_valid`=`req_vld`; `inst_pc`=`req_pc`.
  - No stall, no redirect: issue `req_pc`+4 with `imem_en`=1. Next edge: `req_pc` += 4.
  - Stall, no redirect: `imem_en`=0. Next edge: capture `imem_dout` into `hold_inst` and go to HOLD; `req_pc` unchanged.
- HOLD:
  - Outputs: `inst`=`hold_inst`, `inst_valid`=`req_vld`, `inst_pc`=`req_pc`.
  - Stall remains: `imem_en`=0; stay in HOLD.
  - Stall drops: issue `req_pc`+4. Next edge: RUN with `req_pc` += 4.
- Redirect, in any non-reset cycle, has priority over `stall`:
  - Same cycle, combinationally: `inst`=NOP_INST, `inst_valid`=0.
  - Issue `{redirect_pc[31:2],2'b00}` with `imem_en`=1.
  - Next edge: `req_pc`=that target, `req_vld`=1, state RUN.
  - Penalty: exactly one bubble.
- PC arithmetic is 32-bit modulo: 32'hFFFF_FFFC + 4 = 0.
- The field outputs always decode the `inst` output, so a bubble presents opcode 7'h13, funct3 0, bit30 0.
- `fetch_cnt` increments (mod 2^32) on each edge where `inst_valid`=1, `stall`=0 and `redirect`=0.

## Timing
- Fetch latency: address is issued in cycle t; the instruction is visible on `inst` in cycle t+1.
- After reset release, assuming `rst`=1 from edge E1 onward:
  - Cycle after E0: BOOT.
  - Cycle after E1: `inst`=mem[RESET_PC], `inst_pc`=RESET_PC, `inst_valid`=1.
- Steady state: one instruction per cycle.
- Stall of N cycles: the same `inst`/`inst_pc` is presented N+1 cycles, and no instruction is lost or duplicated after release.
- `redirect` with `stall`: the redirect wins, and the held instruction is discarded.
- `rst` low mid-stream, including in HOLD: the next cycle is BOOT regardless of other inputs.
- All paths from `redirect`/`stall` to `imem_addr`/`imem_en`/`inst_valid` are combinational; everything else is registered.

## Test plan
- Reset then run over imem holding `0x00100093`, `0x00200113`, `0x002081B3` at 0x4000_0000/4/8:
  - After E1: `inst_pc` = 0x4000_0000, 0x4000_0004, 0x4000_0008 on consecutive cycles.
  - `opcode` = 0x13, 0x13, 0x33; `inst_bit30`=0.
  - `fetch_cnt`=3 after the third edge.
- Stall 3 cycles while `inst_pc`=0x4000_0004:
  - `inst`=0x00200113 is held for 4 cycles with `imem_en`=0.
  - The next instruction is 0x4000_0008.
  - `fetch_cnt` does not advance during the stall.
- Redirect to 0x4000_0103 while 0x4000_0008 is on the output:
  - That cycle: `inst_valid`=0, `inst`=0x13, `imem_addr`=0x4000_0100.
  - Next cycle: `inst_pc`=0x4000_0100.
- `redirect`+`stall` asserted together in HOLD: `imem_addr`=target, and the next cycle presents the target instruction with state RUN.
- PC wrap: redirect to 0xFFFF_FFFC, then run: the next `inst_pc` is 0x0000_0000.
- `rst`=0 for one edge in HOLD:
  - Following cycle: BOOT, `inst_valid`=0, `imem_addr`=0x4000_0000.
  - `fetch_cnt`=0.

Source files
------------

// File: rtl/fetch_stage_if.sv
// Fetch-stage bus bundle: instruction-memory port plus the decode-side
// instruction/control handshake. The fetch stage is the master.
interface fetch_stage_if;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic [31:0] imem_addr;
    logic        imem_en;
    logic [31:0] imem_dout;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        inst_valid;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic        inst_bit30;
    logic [31:0] fetch_cnt;

    modport master (
        input  stall, redirect, redirect_pc, imem_dout,
        output imem_addr, imem_en, inst, inst_pc, inst_valid,
               opcode, funct3, inst_bit30, fetch_cnt
    );

    modport slave (
        output stall, redirect, redirect_pc, imem_dout,
        input  imem_addr, imem_en, inst, inst_pc, inst_valid,
               opcode, funct3, inst_bit30, fetch_cnt
    );
endinterface

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, drives a 1-cycle-latency instruction
// memory, buffers the returned word across decode stalls and kills the
// wrong-path instruction on an execute redirect (one-bubble penalty).
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h4000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic          clk,
    input  logic          rst,
    fetch_stage_if.master bus
);

    typedef enum logic [1:0] {BOOT, RUN, HOLD} state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [31:0] r_req_pc;
    logic        r_req_vld;
    logic [31:0] r_hold_inst;
    logic [31:0] r_fetch_cnt;

    logic [31:0] w_tgt;
    logic [31:0] w_pc_inc;
    logic [31:0] w_pc_nxt;
    logic        w_vld_nxt;
    logic        w_capture;
    logic [31:0] w_addr;
    logic        w_en;
    logic [31:0] w_inst;
    logic        w_valid;
    logic [31:0] w_inst_pc;

    // Next-state, memory request and decode-side outputs; redirect overrides all.
    always_comb begin
        w_tgt       = bus.redirect_pc & 32'hFFFF_FFFC;
        w_pc_inc    = r_req_pc + 32'd4;
        w_state_nxt = r_state;
        w_pc_nxt    = r_req_pc;
        w_vld_nxt   = r_req_vld;
        w_capture   = 1'b0;
        w_addr      = w_pc_inc;
        w_en        = 1'b0;
        w_inst      = NOP_INST;
        w_valid     = 1'b0;
        w_inst_pc   = r_req_pc;

        case (r_state)
            BOOT: begin
                w_addr      = RESET_PC;
                w_en        = 1'b1;
                w_inst_pc   = RESET_PC;
                w_pc_nxt    = RESET_PC;
                w_vld_nxt   = 1'b1;
                w_state_nxt = RUN;
            end
            RUN: begin
                w_inst  = r_req_vld ? bus.imem_dout : NOP_INST;
                w_valid = r_req_vld;
                if (bus.stall) begin
                    // Memory output is only good this cycle; park it.
                    w_capture   = 1'b1;
                    w_state_nxt = HOLD;
                end else begin
                    w_en     = 1'b1;
                    w_pc_nxt = w_pc_inc;
                end
            end
            HOLD: begin
                w_inst  = r_hold_inst;
                w_valid = r_req_vld;
                if (!bus.stall) begin
                    w_en        = 1'b1;
                    w_pc_nxt    = w_pc_inc;
                    w_state_nxt = RUN;
                end
            end
            default: begin
                w_state_nxt = BOOT;
            end
        endcase

        if (bus.redirect) begin
            w_inst      = NOP_INST;
            w_valid     = 1'b0;
            w_addr      = w_tgt;
            w_en        = 1'b1;
            w_pc_nxt    = w_tgt;
            w_vld_nxt   = 1'b1;
            w_capture   = 1'b0;
            w_state_nxt = RUN;
        end
    end

    // State, PC, hold buffer and accepted-instruction counter.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state     <= BOOT;
            r_req_pc    <= RESET_PC;
            r_req_vld   <= 1'b0;
            r_hold_inst <= NOP_INST;
            r_fetch_cnt <= 32'd0;
        end else begin
            r_state   <= w_state_nxt;
            r_req_pc  <= w_pc_nxt;
            r_req_vld <= w_vld_nxt;
            if (w_capture) begin
                r_hold_inst <= bus.imem_dout;
            end
            if (w_valid && !bus.stall) begin
                r_fetch_cnt <= r_fetch_cnt + 32'd1;
            end
        end
    end

    assign bus.imem_addr  = w_addr;
    assign bus.imem_en    = w_en;
    assign bus.inst       = w_inst;
    assign bus.inst_pc    = w_inst_pc;
    assign bus.inst_valid = w_valid;
    assign bus.opcode     = w_inst[6:0];
    assign bus.funct3     = w_inst[14:12];
    assign bus.inst_bit30 = w_inst[30];
    assign bus.fetch_cnt  = r_fetch_cnt;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: sync memory model, directed scenarios with literal
// expectations, then randomized stall/redirect/reset traffic against a
// PC-stream reference model.
module tb_fetch_stage;

    localparam logic [31:0] RESET_PC = 32'h4000_0000;
    localparam logic [31:0] NOP_INST = 32'h0000_0013;

    logic clk;
    logic rst;
    fetch_stage_if ifc ();

    fetch_stage dut (
        .clk (clk),
        .rst (rst),
        .bus (ifc.master)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int checks;
    int failures;

    function automatic logic [31:0] memf(input logic [31:0] a);
        case (a)
            32'h4000_0000: memf = 32'h0010_0093;
            32'h4000_0004: memf = 32'h0020_0113;
            32'h4000_0008: memf = 32'h0020_81B3;
            default:       memf = (a * 32'h9E37_79B1) ^ 32'hA5A5_0F0F;
        endcase
    endfunction

    // Synchronous memory; output is garbage after a cycle without enable.
    always @(posedge clk) begin
        ifc.imem_dout <= ifc.imem_en ? memf(ifc.imem_addr) : $urandom;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference model: the PC that should be on the output, boot flag, count.
    logic [31:0] m_pc;
    logic        m_boot;
    logic [31:0] m_cnt;
    logic        chk_on;

    // Snapshot of DUT outputs from the last cycle, for literal checks.
    logic [31:0] s_inst, s_pc, s_addr, s_cnt;
    logic        s_valid, s_en, s_b30;
    logic [6:0]  s_op;

    task automatic cyc(input logic r, input logic s, input logic d, input logic [31:0] t);
        logic [31:0] e_inst, e_pc, e_addr, tgt;
        logic        e_valid, e_en;
        rst             = r;
        ifc.stall       = s;
        ifc.redirect    = d;
        ifc.redirect_pc = t;
        @(negedge clk);
        tgt = {t[31:2], 2'b00};
        if (d) begin
            e_valid = 1'b0; e_inst = NOP_INST; e_en = 1'b1; e_addr = tgt;
            e_pc = m_boot ? RESET_PC : m_pc;
        end else if (m_boot) begin
            e_valid = 1'b0; e_inst = NOP_INST; e_en = 1'b1; e_addr = RESET_PC;
            e_pc = RESET_PC;
        end else begin
            e_valid = 1'b1; e_inst = memf(m_pc); e_en = !s; e_addr = m_pc + 32'd4;
            e_pc = m_pc;
        end
        if (chk_on) begin
            chk("inst_valid", {31'd0, ifc.inst_valid}, {31'd0, e_valid});
            chk("inst", ifc.inst, e_inst);
            chk("opcode", {25'd0, ifc.opcode}, {25'd0, e_inst[6:0]});
            chk("funct3", {29'd0, ifc.funct3}, {29'd0, e_inst[14:12]});
            chk("inst_bit30", {31'd0, ifc.inst_bit30}, {31'd0, e_inst[30]});
            chk("imem_en", {31'd0, ifc.imem_en}, {31'd0, e_en});
            if (e_en) chk("imem_addr", ifc.imem_addr, e_addr);
            if (!d) chk("inst_pc", ifc.inst_pc, e_pc);
            chk("fetch_cnt", ifc.fetch_cnt, m_cnt);
        end
        s_inst = ifc.inst; s_pc = ifc.inst_pc; s_addr = ifc.imem_addr;
        s_cnt = ifc.fetch_cnt; s_valid = ifc.inst_valid; s_en = ifc.imem_en;
        s_b30 = ifc.inst_bit30; s_op = ifc.opcode;
        if (!r) begin
            m_boot = 1'b1; m_cnt = 32'd0; m_pc = RESET_PC;
        end else if (d) begin
            m_boot = 1'b0; m_pc = tgt;
        end else if (m_boot) begin
            m_boot = 1'b0; m_pc = RESET_PC;
        end else if (!s) begin
            m_cnt = m_cnt + 32'd1; m_pc = m_pc + 32'd4;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic        rr, ss, dd;
        logic [31:0] tt;
        checks = 0; failures = 0; chk_on = 1'b0;
        m_pc = RESET_PC; m_boot = 1'b1; m_cnt = 32'd0;

        cyc(1'b0, 1'b0, 1'b0, 32'd0);
        cyc(1'b0, 1'b0, 1'b0, 32'd0);
        chk_on = 1'b1;

        // BOOT
        cyc(1'b1, 1'b0, 1'b0, 32'd0);
        chk("lit_boot_valid", {31'd0, s_valid}, 32'd0);
        chk("lit_boot_addr", s_addr, 32'h4000_0000);
        chk("lit_boot_cnt", s_cnt, 32'd0);
        // c1
        cyc(1'b1, 1'b0, 1'b0, 32'd0);
        chk("lit_c1_pc", s_pc, 32'h4000_0000);
        chk("lit_c1_op", {25'd0, s_op}, 32'h13);
        chk("lit_c1_valid", {31'd0, s_valid}, 32'd1);
        // c2..c5: stall 3 cycles on 0x4000_0004
        for (int i = 0; i < 3; i++) begin
            cyc(1'b1, 1'b1, 1'b0, 32'd0);
            chk("lit_stall_pc", s_pc, 32'h4000_0004);
            chk("lit_stall_inst", s_inst, 32'h0020_0113);
            chk("lit_stall_en", {31'd0, s_en}, 32'd0);
            chk("lit_stall_cnt", s_cnt, 32'd1);
        end
        cyc(1'b1, 1'b0, 1'b0, 32'd0);
        chk("lit_release_inst", s_inst, 32'h0020_0113);
        chk("lit_release_cnt", s_cnt, 32'd1);
        // c6: 0x4000_0008, stalled into HOLD
        cyc(1'b1, 1'b1, 1'b0, 32'd0);
        chk("lit_c6_pc", s_pc, 32'h4000_0008);
        chk("lit_c6_op", {25'd0, s_op}, 32'h33);
        chk("lit_c6_b30", {31'd0, s_b30}, 32'd0);
        chk("lit_c6_cnt", s_cnt, 32'd2);
        // c7: redirect to 0x4000_0103 while 0x4000_0008 is held
        cyc(1'b1, 1'b0, 1'b1, 32'h4000_0103);
        chk("lit_redir_valid", {31'd0, s_valid}, 32'd0);
        chk("lit_redir_inst", s_inst, 32'h13);
        chk("lit_redir_addr", s_addr, 32'h4000_0100);
        // c8: target arrives, stall into HOLD
        cyc(1'b1, 1'b1, 1'b0, 32'd0);
        chk("lit_tgt_pc", s_pc, 32'h4000_0100);
        chk("lit_tgt_cnt", s_cnt, 32'd2);
        // c9: redirect + stall in HOLD
        cyc(1'b1, 1'b1, 1'b1, 32'h4000_0200);
        chk("lit_rs_addr", s_addr, 32'h4000_0200);
        chk("lit_rs_valid", {31'd0, s_valid}, 32'd0);
        // c10: target presented; redirect to wrap point
        cyc(1'b1, 1'b0, 1'b1, 32'hFFFF_FFFE);
        chk("lit_rs_pc", s_pc, 32'h4000_0200);
        chk("lit_wrap_addr", s_addr, 32'hFFFF_FFFC);
        cyc(1'b1, 1'b0, 1'b0, 32'd0);
        chk("lit_wrap_pc0", s_pc, 32'hFFFF_FFFC);
        cyc(1'b1, 1'b0, 1'b0, 32'd0);
        chk("lit_wrap_pc1", s_pc, 32'h0000_0000);
        chk("lit_wrap_cnt", s_cnt, 32'd3);
        // reset while in HOLD
        cyc(1'b1, 1'b1, 1'b0, 32'd0);
        cyc(1'b0, 1'b1, 1'b0, 32'd0);
        cyc(1'b1, 1'b1, 1'b0, 32'd0);
        chk("lit_rst_valid", {31'd0, s_valid}, 32'd0);
        chk("lit_rst_addr", s_addr, 32'h4000_0000);
        chk("lit_rst_cnt", s_cnt, 32'd0);

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            rr = ($urandom_range(0, 99) >= 2);
            ss = ($urandom_range(0, 99) < 35);
            dd = ($urandom_range(0, 99) < 10);
            if ($urandom_range(0, 3) == 0)
                tt = 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
            else
                tt = 32'h4000_0000 + 32'($urandom_range(0, 4095));
            cyc(rr, ss, dd, tt);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
